spi_reg_master: RTL

- SPI mode-0 initiator that issues one register transaction per request: a command byte, then a data byte.
- It is the host-side counterpart to the on-chip SPI register target.
- Used in loopback benches and by on-chip controllers that drive the register target over 4 wires.
- Generates spi_clk/spi_cs_n from clk, shifts the command/write data out, and captures the target's status byte and read data.

---
 rtl/spi_reg_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// SPI mode-0 register initiator.
// Each accepted request produces one chip-select frame with a command byte
// followed by a data byte, both sent MSB first. The byte received during the
// command phase is reported as status. The byte received during the data phase
// is reported as rdata, but only for reads.
module spi_reg_master #(
    parameter int ADDR_W     = 3,
    parameter int REG_W      = 8,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int CS_IDLE    = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [REG_W-1:0]  rdata,
    output logic [7:0]        status,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    input  logic              spi_miso
);

    // The terminal counts below are used as "last cycle of this phase" markers.
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] IDLE_LAST = 16'(CS_IDLE - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(REG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_GAP,
        S_DATA,
        S_IDLEWAIT
    } state_t;

    state_t           state_q;
    logic [15:0]      cnt_q;        // clk cycles spent in the current half-bit / phase
    logic [2:0]       bit_q;        // bit index within the current byte
    logic             rw_q;
    logic [REG_W-1:0] data_q;       // byte to send in the data phase
    logic [REG_W-1:0] tx_q;         // outgoing shift register; tx_q[MSB] is on the wire
    logic [REG_W-1:0] rx_q;         // incoming shift register
    logic [REG_W-1:0] stat_cap_q;   // command-phase capture, held until done
    logic             busy_q;
    logic             done_q;
    logic [REG_W-1:0] rdata_q;
    logic [REG_W-1:0] status_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             cs_n_q;

    // Values loaded when a request is accepted.
    logic [REG_W-1:0] cmd_d;
    logic [REG_W-1:0] data_d;

    assign cmd_d  = {rw, {(REG_W - 1 - ADDR_W){1'b0}}, addr};
    assign data_d = rw ? wdata : '0;

    // Frame sequencer: divider, bit counter, shift registers and registered pins.
    always_ff @(posedge clk) begin
        // NOTE: reset is tested inside the clocked block. This makes it synchronous,
        // and it wins over ena so that an abort always takes effect on the next edge.
        if (!rstb) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            rw_q       <= 1'b0;
            data_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            stat_cap_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            status_q   <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else if (ena) begin
            // NOTE: all state uses non-blocking assignments. Every branch therefore
            // reads the pre-edge values, so branch order cannot change the result.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // busy_q is always low in IDLE, so start alone qualifies.
                    if (start) begin
                        rw_q    <= rw;
                        data_q  <= data_d;
                        tx_q    <= cmd_d;
                        mosi_q  <= cmd_d[REG_W-1];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[REG_W-2:0], spi_miso};
                        state_q <= S_CMD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_CMD, S_DATA: begin
                    if (cnt_q != DIV_LAST) begin
                        cnt_q <= cnt_q + 16'd1;
                    end else begin
                        cnt_q <= '0;
                        if (sclk_q) begin
                            // End of the high half: fall, and advance MOSI unless this was the last bit.
                            sclk_q <= 1'b0;
                            if (bit_q != LAST_BIT) begin
                                tx_q   <= {tx_q[REG_W-2:0], 1'b0};
                                mosi_q <= tx_q[REG_W-2];
                            end
                        end else if (bit_q != LAST_BIT) begin
                            // End of the low half: rise and sample MISO.
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[REG_W-2:0], spi_miso};
                            bit_q  <= bit_q + 3'd1;
                        end else if (state_q == S_CMD) begin
                            stat_cap_q <= rx_q;
                            tx_q       <= data_q;
                            mosi_q     <= data_q[REG_W-1];
                            state_q    <= S_GAP;
                        end else begin
                            cs_n_q   <= 1'b1;
                            done_q   <= 1'b1;
                            mosi_q   <= 1'b0;
                            status_q <= stat_cap_q;
                            if (!rw_q) begin
                                rdata_q <= rx_q;
                            end
                            state_q  <= S_IDLEWAIT;
                        end
                    end
                end

                S_GAP: begin
                    // spi_clk stays low so the target can decode the command and stage read data.
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[REG_W-2:0], spi_miso};
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_IDLEWAIT: begin
                    if (cnt_q == IDLE_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign status   = status_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule
